// File: rtl/spmmio_pkg.sv
// spmmio_pkg: shared types and constants for the SPMMIO bus bridge.
package spmmio_pkg;
  typedef enum logic {IDLE, BUS} state_t;
  localparam int SPMMIO_ADR_W = 24;
  localparam logic [31:0] SPMMIO_ERR_DATA = 32'hFFFFFFFF;
endpackage

// File: rtl/spmmio_bus_bridge.sv
// spmmio_bus_bridge: CPU data port to SPMMIO Wishbone-style master, posted stores and ack watchdog.
module spmmio_bus_bridge
  import spmmio_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1023,
  parameter bit posted_writes = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [0:21]             cpu_adr,
  input  logic [0:3]              cpu_sel,
  input  logic [0:31]             cpu_wdat,
  output logic                    cpu_ack,
  output logic [0:31]             cpu_rdat,
  output logic                    cpu_err,
  output logic [0:SPMMIO_ADR_W-1] adr_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic [0:3]              sel_o,
  output logic                    we_o,
  output logic [0:31]             dat_o,
  input  logic                    ack_i,
  input  logic [0:31]             dat_i,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [0:21]             err_adr
);
  state_t state, state_nx;
  logic [21:0] req_adr, eadr;
  logic [3:0] req_sel;
  logic [31:0] req_dat, rdat;
  logic req_we, accept, done, abort, wd_hit, resp;
  logic [15:0] wd;
  assign wd_hit = ({1'b0, wd} + 17'd1) >= 17'(timeout_cycles);
  // a posted store was already acked on issue, so only loads and unposted stores answer at the end
  assign resp = !req_we || !posted_writes;
  always_comb begin
    accept = state == IDLE && cpu_req && !cpu_ack;
    done = state == BUS && ack_i;
    abort = state == BUS && !ack_i && wd_hit;
    state_nx = accept ? BUS : (done || abort) ? IDLE : state;
  end
  assign cyc_o = state == BUS;
  assign stb_o = state == BUS;
  assign adr_o = {req_adr, {(SPMMIO_ADR_W-22){1'b0}}};
  assign sel_o = req_sel;
  assign we_o = req_we;
  assign dat_o = req_dat;
  assign cpu_rdat = rdat;
  assign err_adr = eadr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      req_adr <= '0;
      req_sel <= '0;
      req_we <= 1'b0;
      req_dat <= '0;
      wd <= '0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      rdat <= '0;
      bus_err <= 1'b0;
      eadr <= '0;
    end else begin
      state <= state_nx;
      wd <= accept ? '0 : (state == BUS && wd != '1) ? wd + 16'd1 : wd;
      cpu_ack <= (accept && cpu_we && posted_writes) || ((done || abort) && resp);
      cpu_err <= abort && !req_we;
      if (accept) begin
        req_adr <= cpu_adr;
        req_sel <= cpu_sel;
        req_we <= cpu_we;
        req_dat <= cpu_wdat;
      end
      if ((done || abort) && !req_we)
        rdat <= abort ? SPMMIO_ERR_DATA : dat_i;
      // a fresh abort outranks a clear arriving in the same cycle
      if (abort && (!bus_err || err_clr)) begin
        bus_err <= 1'b1;
        eadr <= req_adr;
      end else if (err_clr)
        bus_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spmmio_bus_bridge.sv
// tb_spmmio_bus_bridge: directed and randomized checks of the bridge against a TB slave and memory model.
module tb_spmmio_bus_bridge;
  logic clk = 1'b0, reset = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, err_clr = 1'b0;
  logic [21:0] cpu_adr = '0;
  logic [3:0] cpu_sel = '0;
  logic [31:0] cpu_wdat = '0;
  logic cpu_ack, cpu_err, bus_err, cyc_o, stb_o, we_o, ack_i;
  logic [31:0] cpu_rdat, dat_o, dat_i;
  logic [23:0] adr_o;
  logic [3:0] sel_o;
  logic [21:0] err_adr;
  int slv_delay = 0, slv_cnt = 0, n_tests = 0, n_fail = 0;
  bit slv_dead = 0, ovr_en = 0;
  logic [31:0] ovr_dat = '0;
  bit [31:0] mem [256];
  bit [31:0] ref_mem [256];

  spmmio_bus_bridge #(.timeout_cycles(8), .posted_writes(1'b1)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_sel(cpu_sel), .cpu_wdat(cpu_wdat), .cpu_ack(cpu_ack), .cpu_rdat(cpu_rdat),
    .cpu_err(cpu_err), .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o),
    .we_o(we_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i), .err_clr(err_clr),
    .bus_err(bus_err), .err_adr(err_adr)
  );

  always #5 clk = ~clk;

  // slave: acks after slv_delay strobe cycles unless dead
  assign ack_i = stb_o && !slv_dead && slv_cnt == slv_delay;
  assign dat_i = ovr_en ? ovr_dat : mem[adr_o[9:2]];
  always @(posedge clk) begin
    slv_cnt <= stb_o ? slv_cnt + 1 : 0;
    if (ack_i && we_o)
      for (int i = 0; i < 4; i++)
        if (sel_o[i]) mem[adr_o[9:2]][8*i +: 8] <= dat_o[8*i +: 8];
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input bit we, input logic [21:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, input int delay, input bit dead, input int clr_at,
                           output int stb_n, output int ack_at, output int n_ack, output bit err,
                           output logic [31:0] rdat, output bit stable);
    slv_delay = delay;
    slv_dead = dead;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_adr = adr;
    cpu_sel = sel;
    cpu_wdat = wdat;
    stb_n = 0;
    ack_at = -1;
    n_ack = 0;
    err = 0;
    rdat = 'x;
    stable = 1;
    for (int n = 1; n <= 60; n++) begin
      tick;
      err_clr = (n == clr_at);
      if (stb_o) begin
        stb_n++;
        if (adr_o !== {adr, 2'b00} || sel_o !== sel || we_o !== we || !cyc_o || (we && dat_o !== wdat))
          stable = 0;
      end
      if (cpu_ack) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = n;
          err = cpu_err;
          rdat = cpu_rdat;
        end
        cpu_req = 1'b0;
      end
      if (n_ack > 0 && !stb_o && !cpu_ack) break;
    end
    cpu_req = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    n_tests++;
    if ({cyc_o, stb_o, we_o, cpu_ack, cpu_err, bus_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000", {cyc_o, stb_o, we_o, cpu_ack, cpu_err, bus_err});
    end
    n_tests++;
    if (adr_o !== '0 || sel_o !== '0 || dat_o !== '0 || cpu_rdat !== '0 || err_adr !== '0) begin
      n_fail++;
      $display("FAIL reset_data: adr %h sel %h dat %h rdat %h eadr %h want all 0", adr_o, sel_o, dat_o, cpu_rdat, err_adr);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_read;
    int stb_n, ack_at, n_ack;
    bit err, stable;
    logic [31:0] rdat;
    ovr_en = 1;
    ovr_dat = 32'h12345678;
    do_access(0, 22'h000123, 4'hF, 0, 0, 0, -1, stb_n, ack_at, n_ack, err, rdat, stable);
    ovr_en = 0;
    n_tests++;
    if (ack_at !== 2 || stb_n !== 1 || n_ack !== 1) begin
      n_fail++;
      $display("FAIL read_timing: ack_at %0d stb %0d acks %0d want 2 1 1", ack_at, stb_n, n_ack);
    end
    n_tests++;
    if (rdat !== 32'h12345678 || err !== 0 || !stable) begin
      n_fail++;
      $display("FAIL read_data: rdat %h err %b stable %b want 12345678 0 1", rdat, err, stable);
    end
  endtask

  task automatic test_posted_write;
    bit ok1, ok2, ok3;
    logic [31:0] rd;
    slv_delay = 0;
    slv_dead = 0;
    cpu_req = 1;
    cpu_we = 1;
    cpu_adr = 22'h000004;
    cpu_sel = 4'b0011;
    cpu_wdat = 32'hCAFEF00D;
    tick;
    ok1 = stb_o && cpu_ack && we_o && dat_o === 32'hCAFEF00D && sel_o === 4'b0011 && adr_o === 24'h000010;
    cpu_we = 0;
    cpu_adr = 22'h000004;
    cpu_sel = 4'hF;
    tick;
    ok2 = !stb_o && !cpu_ack;
    tick;
    ok3 = stb_o && !we_o && adr_o === 24'h000010;
    tick;
    rd = cpu_rdat;
    n_tests++;
    if (!ok1) begin
      n_fail++;
      $display("FAIL posted_cycle1: stb %b ack %b we %b dat %h sel %b adr %h want 1 1 1 cafef00d 0011 000010", stb_o, cpu_ack, we_o, dat_o, sel_o, adr_o);
    end
    n_tests++;
    if (!ok2 || !ok3) begin
      n_fail++;
      $display("FAIL posted_b2b: cycle2_idle %b cycle3_readstb %b want 1 1", ok2, ok3);
    end
    n_tests++;
    if (!cpu_ack || rd !== 32'h0000F00D) begin
      n_fail++;
      $display("FAIL posted_readback: ack %b rdat %h want 1 0000f00d", cpu_ack, rd);
    end
    cpu_req = 0;
    tick;
  endtask

  task automatic test_slow_slave;
    int stb_n, ack_at, n_ack;
    bit err, stable;
    logic [31:0] rdat;
    do_access(1, 22'h000040, 4'hF, 32'hA5A55A5A, 5, 0, -1, stb_n, ack_at, n_ack, err, rdat, stable);
    n_tests++;
    if (stb_n !== 6 || ack_at !== 1 || n_ack !== 1 || !stable) begin
      n_fail++;
      $display("FAIL slow_write: stb %0d ack_at %0d acks %0d stable %b want 6 1 1 1", stb_n, ack_at, n_ack, stable);
    end
    do_access(0, 22'h000040, 4'hF, 0, 5, 0, -1, stb_n, ack_at, n_ack, err, rdat, stable);
    n_tests++;
    if (stb_n !== 6 || ack_at !== 7 || n_ack !== 1 || !stable || rdat !== 32'hA5A55A5A) begin
      n_fail++;
      $display("FAIL slow_read: stb %0d ack_at %0d acks %0d stable %b rdat %h want 6 7 1 1 a5a55a5a", stb_n, ack_at, n_ack, stable, rdat);
    end
  endtask

  task automatic test_timeout;
    int stb_n, ack_at, n_ack;
    bit err, stable;
    logic [31:0] rdat;
    do_access(0, 22'h1FC000, 4'hF, 0, 0, 1, -1, stb_n, ack_at, n_ack, err, rdat, stable);
    n_tests++;
    if (stb_n !== 8 || ack_at !== 9 || n_ack !== 1 || err !== 1 || rdat !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL timeout_read: stb %0d ack_at %0d acks %0d err %b rdat %h want 8 9 1 1 ffffffff", stb_n, ack_at, n_ack, err, rdat);
    end
    n_tests++;
    if (bus_err !== 1 || err_adr !== 22'h1FC000) begin
      n_fail++;
      $display("FAIL timeout_flag: bus_err %b err_adr %h want 1 1fc000", bus_err, err_adr);
    end
    do_access(0, 22'h1FC001, 4'hF, 0, 0, 1, -1, stb_n, ack_at, n_ack, err, rdat, stable);
    n_tests++;
    if (bus_err !== 1 || err_adr !== 22'h1FC000 || err !== 1) begin
      n_fail++;
      $display("FAIL timeout_second: bus_err %b err_adr %h err %b want 1 1fc000 1", bus_err, err_adr, err);
    end
  endtask

  task automatic test_err_clr;
    int stb_n, ack_at, n_ack;
    bit err, stable;
    logic [31:0] rdat;
    do_access(0, 22'h0ABCDE, 4'hF, 0, 0, 1, 8, stb_n, ack_at, n_ack, err, rdat, stable);
    n_tests++;
    if (bus_err !== 1 || err_adr !== 22'h0ABCDE || stb_n !== 8) begin
      n_fail++;
      $display("FAIL clr_collide: bus_err %b err_adr %h stb %0d want 1 0abcde 8", bus_err, err_adr, stb_n);
    end
    err_clr = 1;
    tick;
    err_clr = 0;
    n_tests++;
    if (bus_err !== 0) begin
      n_fail++;
      $display("FAIL clr_lone: bus_err %b want 0", bus_err);
    end
  endtask

  task automatic test_reset_mid;
    int stb_n, ack_at, n_ack;
    bit err, stable, seen_ack, was_stb;
    logic [31:0] rdat;
    slv_dead = 1;
    cpu_req = 1;
    cpu_we = 0;
    cpu_adr = 22'h00002A;
    repeat (3) tick;
    was_stb = stb_o;
    #2 reset = 0;
    #1;
    n_tests++;
    if (!was_stb || cyc_o !== 0 || stb_o !== 0) begin
      n_fail++;
      $display("FAIL reset_async: before %b cyc %b stb %b want 1 0 0", was_stb, cyc_o, stb_o);
    end
    cpu_req = 0;
    seen_ack = 0;
    repeat (3) begin
      tick;
      seen_ack |= cpu_ack;
    end
    reset = 1;
    tick;
    seen_ack |= cpu_ack;
    n_tests++;
    if (seen_ack || bus_err !== 0) begin
      n_fail++;
      $display("FAIL reset_noack: ack_seen %b bus_err %b want 0 0", seen_ack, bus_err);
    end
    ovr_en = 1;
    ovr_dat = 32'h0BADF00D;
    do_access(0, 22'h00002A, 4'hF, 0, 2, 0, -1, stb_n, ack_at, n_ack, err, rdat, stable);
    ovr_en = 0;
    n_tests++;
    if (ack_at !== 4 || rdat !== 32'h0BADF00D || err !== 0 || n_ack !== 1) begin
      n_fail++;
      $display("FAIL reset_recover: ack_at %0d rdat %h err %b acks %0d want 4 0badf00d 0 1", ack_at, rdat, err, n_ack);
    end
  endtask

  task automatic test_random;
    int stb_n, ack_at, n_ack, delay, exp_stb, exp_ack;
    bit err, stable, we, dead, to, exp_be;
    logic [31:0] rdat, wdat, exp_rd;
    logic [21:0] a, exp_ea;
    logic [3:0] sel;
    exp_be = bus_err;
    exp_ea = err_adr;
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1));
      a = {14'($urandom), 8'(16 + $urandom_range(0, 15))};
      sel = 4'($urandom);
      wdat = $urandom;
      delay = $urandom_range(0, 9);
      dead = $urandom_range(0, 7) == 0;
      to = dead || delay >= 8;
      exp_stb = to ? 8 : delay + 1;
      exp_ack = we ? 1 : exp_stb + 1;
      exp_rd = to ? 32'hFFFFFFFF : ref_mem[a[7:0]];
      do_access(we, a, sel, wdat, delay, dead, -1, stb_n, ack_at, n_ack, err, rdat, stable);
      n_tests++;
      if (stb_n !== exp_stb || ack_at !== exp_ack || n_ack !== 1 || !stable) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: stb %0d ack_at %0d acks %0d stable %b want %0d %0d 1 1", k, stb_n, ack_at, n_ack, stable, exp_stb, exp_ack);
      end
      if (!we) begin
        n_tests++;
        if (rdat !== exp_rd || err !== to) begin
          n_fail++;
          $display("FAIL rand_read[%0d]: rdat %h err %b want %h %b", k, rdat, err, exp_rd, to);
        end
      end
      if (we && !to)
        for (int i = 0; i < 4; i++)
          if (sel[i]) ref_mem[a[7:0]][8*i +: 8] = wdat[8*i +: 8];
      if (to && !exp_be) begin
        exp_be = 1;
        exp_ea = a;
      end
      n_tests++;
      if (bus_err !== exp_be || (exp_be && err_adr !== exp_ea)) begin
        n_fail++;
        $display("FAIL rand_err[%0d]: bus_err %b err_adr %h want %b %h", k, bus_err, err_adr, exp_be, exp_ea);
      end
      if ($urandom_range(0, 5) == 0) begin
        err_clr = 1;
        tick;
        err_clr = 0;
        exp_be = 0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_posted_write;
    test_slow_slave;
    test_timeout;
    test_err_clr;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
